// File: rtl/mmio_peripherals.sv
// mmio_peripherals
//   Memory-mapped peripheral block that sits behind the MEM stage. It decodes
//   a 32-byte window at BASE_ADDR and provides:
//     0x00 TH      timer reload value
//     0x04 TL      timer count
//     0x08 TCON    {status, irq enable, enable}
//     0x0C LED     8-bit LED register
//     0x10 DIGITS  four hex nibbles + bit16 decimal-point gate
//     0x14 SYSTICK free-running cycle counter (only with MMIO_SYSTICK_EN)
//     0x18/0x1C    read 0, writes ignored
//   Optional feature macro: MMIO_SYSTICK_EN (undefined -> 0x14 reads 0).
//
// Ports
//   clk    system clock
//   reset  synchronous, active-high
//   addr   byte address (addr[4:2] selects the register, addr[1:0] ignored)
//   wdata  store data, always written as a full word
//   rd_en  load strobe; rdata is zero unless rd_en && hit
//   wr_en  store strobe; write happens at the edge when wr_en && hit
//   hit    address falls inside the peripheral window (combinational)
//   rdata  combinational read data of the current register value
//   irq    TCON[1] & TCON[2]
//   leds   LED register
//   bcd7   active-low segments {dp,g,f,e,d,c,b,a}, registered
//   an     active-low one-hot digit enables, registered
module mmio_peripherals #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int          SCAN_DIV  = 100000,
    parameter int          SCAN_W    = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [7:0]  leds,
    output logic [7:0]  bcd7,
    output logic [3:0]  an
);

    logic [31:0]       thReg, thNext;
    logic [31:0]       tlReg, tlNext;
    logic [2:0]        tconReg, tconNext;
    logic [7:0]        ledReg, ledNext;
    logic [16:0]       digitsReg, digitsNext;
    logic [SCAN_W-1:0] scanCntReg, scanCntNext;
    logic [1:0]        digitIdxReg, digitIdxNext;
    logic [3:0]        anReg;
    logic [7:0]        segReg;
    logic [31:0]       sysTickValue;

    logic [2:0] regSel;
    logic       wrHit;
    logic       overflow;
    logic       scanWrap;
    logic [3:0] digitNibble [4];

    // Byte-lane bits play no part in decoding.
    logic unusedAddrBits;
    assign unusedAddrBits = ^addr[1:0];

    assign hit      = (addr[31:5] == BASE_ADDR[31:5]);
    assign regSel   = addr[4:2];
    assign wrHit    = wr_en & hit;
    // Overflow uses the TCON enable as it stands before any write this cycle.
    assign overflow = tconReg[0] & (&tlReg);
    assign scanWrap = (scanCntReg == SCAN_W'(SCAN_DIV - 1));

    function automatic logic [6:0] hexSeg(input logic [3:0] v);
        case (v)
            4'h0:    hexSeg = 7'h40;
            4'h1:    hexSeg = 7'h79;
            4'h2:    hexSeg = 7'h24;
            4'h3:    hexSeg = 7'h30;
            4'h4:    hexSeg = 7'h19;
            4'h5:    hexSeg = 7'h12;
            4'h6:    hexSeg = 7'h02;
            4'h7:    hexSeg = 7'h78;
            4'h8:    hexSeg = 7'h00;
            4'h9:    hexSeg = 7'h10;
            4'hA:    hexSeg = 7'h08;
            4'hB:    hexSeg = 7'h03;
            4'hC:    hexSeg = 7'h46;
            4'hD:    hexSeg = 7'h21;
            4'hE:    hexSeg = 7'h06;
            default: hexSeg = 7'h0E;
        endcase
    endfunction

    always_comb begin
        thNext     = thReg;
        tlNext     = tlReg;
        tconNext   = tconReg;
        ledNext    = ledReg;
        digitsNext = digitsReg;

        // Reload reads thReg, so a TH write in the same cycle only affects
        // later reloads.
        if (tconReg[0]) begin
            if (overflow) begin
                tlNext = thReg;
                if (tconReg[1]) begin
                    tconNext[2] = 1'b1;
                end
            end else begin
                tlNext = tlReg + 32'd1;
            end
        end

        if (wrHit) begin
            case (regSel)
                3'd0: thNext = wdata;
                3'd1: tlNext = wdata;
                // An overflow coinciding with a TCON write still latches the
                // status when the written irq enable is set.
                3'd2: tconNext = {wdata[2] | (wdata[1] & overflow), wdata[1:0]};
                3'd3: ledNext = wdata[7:0];
                3'd4: digitsNext = wdata[16:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        scanCntNext  = scanWrap ? '0 : scanCntReg + SCAN_W'(1);
        digitIdxNext = scanWrap ? digitIdxReg + 2'd1 : digitIdxReg;
    end

    // Display outputs are decoded from the next-state digit index and digit
    // contents so they change on the same edge as the registers they show.
    for (genvar gi = 0; gi < 4; gi++) begin : gNibble
        assign digitNibble[gi] = digitsNext[4*gi +: 4];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            thReg       <= '0;
            tlReg       <= '0;
            tconReg     <= '0;
            ledReg      <= '0;
            digitsReg   <= '0;
            scanCntReg  <= '0;
            digitIdxReg <= '0;
            anReg       <= 4'b1110;
            segReg      <= 8'hC0;
        end else begin
            thReg       <= thNext;
            tlReg       <= tlNext;
            tconReg     <= tconNext;
            ledReg      <= ledNext;
            digitsReg   <= digitsNext;
            scanCntReg  <= scanCntNext;
            digitIdxReg <= digitIdxNext;
            anReg       <= ~(4'b0001 << digitIdxNext);
            segReg      <= {~digitsNext[16], hexSeg(digitNibble[digitIdxNext])};
        end
    end

`ifdef MMIO_SYSTICK_EN
    logic [31:0] sysTickReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sysTickReg <= '0;
        end else begin
            sysTickReg <= sysTickReg + 32'd1;
        end
    end

    assign sysTickValue = sysTickReg;
`else
    assign sysTickValue = '0;
`endif

    always_comb begin
        rdata = '0;
        if (rd_en && hit) begin
            case (regSel)
                3'd0:    rdata = thReg;
                3'd1:    rdata = tlReg;
                3'd2:    rdata = {29'd0, tconReg};
                3'd3:    rdata = {24'd0, ledReg};
                3'd4:    rdata = {15'd0, digitsReg};
                3'd5:    rdata = sysTickValue;
                default: rdata = '0;
            endcase
        end
    end

    assign irq  = tconReg[1] & tconReg[2];
    assign leds = ledReg;
    assign an   = anReg;
    assign bcd7 = segReg;

endmodule

// File: tb/tb_mmio_peripherals.sv
// tb_mmio_peripherals
//   Directed scenarios plus randomized load/store traffic for mmio_peripherals
//   (SCAN_DIV = 4). A behavioural model of the register map, timer and scan
//   position is advanced once per clock and supplies every expected value.
module tb_mmio_peripherals;

    localparam logic [31:0] BASE = 32'h40000000;
    localparam int          SD   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  leds;
    logic [7:0]  bcd7;
    logic [3:0]  an;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state
    logic [31:0] mTh, mTl, mCycles;
    logic [2:0]  mTcon;
    logic [7:0]  mLed;
    logic [16:0] mDigits;

    mmio_peripherals #(
        .BASE_ADDR(BASE),
        .SCAN_DIV (SD),
        .SCAN_W   (20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .wdata(wdata),
        .rd_en(rd_en),
        .wr_en(wr_en),
        .hit  (hit),
        .rdata(rdata),
        .irq  (irq),
        .leds (leds),
        .bcd7 (bcd7),
        .an   (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segOf(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] a, input logic r);
        if (!r || a[31:5] != BASE[31:5]) return 32'd0;
        case (a[4:2])
            3'd0: return mTh;
            3'd1: return mTl;
            3'd2: return {29'd0, mTcon};
            3'd3: return {24'd0, mLed};
            3'd4: return {15'd0, mDigits};
`ifdef MMIO_SYSTICK_EN
            3'd5: return mCycles;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // {leds, irq, an, bcd7}
    function automatic logic [20:0] expOuts();
        int idx;
        idx = int'((mCycles / SD) % 4);
        return {mLed, mTcon[1] & mTcon[2], ~(4'b0001 << idx),
                ~mDigits[16], segOf(mDigits[4*idx +: 4])};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] d,
                         input logic r, input logic w);
        addr  = a;
        wdata = d;
        rd_en = r;
        wr_en = w;
        #1;
    endtask

    // One clock edge; the model consumes the inputs held across the edge.
    task automatic tick();
        logic        ovf;
        logic [31:0] nTh, nTl;
        logic [2:0]  nTcon;
        @(posedge clk);
        if (reset) begin
            mTh = 0; mTl = 0; mTcon = 0; mLed = 0; mDigits = 0; mCycles = 0;
        end else begin
            ovf   = mTcon[0] && (mTl == 32'hFFFFFFFF);
            nTh   = mTh;
            nTl   = mTl;
            nTcon = mTcon;
            if (mTcon[0]) begin
                if (ovf) begin
                    nTl = mTh;
                    if (mTcon[1]) nTcon[2] = 1'b1;
                end else begin
                    nTl = mTl + 1;
                end
            end
            if (wr_en && addr[31:5] == BASE[31:5]) begin
                case (addr[4:2])
                    3'd0: nTh = wdata;
                    3'd1: nTl = wdata;
                    3'd2: nTcon = {wdata[2] | (wdata[1] & ovf), wdata[1:0]};
                    3'd3: mLed = wdata[7:0];
                    3'd4: mDigits = wdata[16:0];
                    default: ;
                endcase
            end
            mTh = nTh; mTl = nTl; mTcon = nTcon;
            mCycles = mCycles + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(BASE + 32'h0C, 32'hFF, 1'b0, 1'b1);  // write during reset is dropped
        tick();
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0);
        tick();
        nChecks++;
        if ({leds, irq, an, bcd7} !== {8'h00, 1'b0, 4'b1110, 8'hC0}) begin
            nFails++;
            $display("FAIL reset_outs: got leds=%h irq=%b an=%b bcd7=%h want 00 0 1110 c0",
                     leds, irq, an, bcd7);
        end
        drive(BASE + 32'h08, 0, 1'b1, 1'b0);
        nChecks++;
        if (rdata !== 32'd0) begin
            nFails++;
            $display("FAIL reset_tcon_read: got %h want 00000000", rdata);
        end
        tick();
    endtask

    task automatic test_led();
        drive(BASE + 32'h0C, 32'h123456A5, 1'b0, 1'b1);
        tick();
        nChecks++;
        if (leds !== 8'hA5) begin
            nFails++;
            $display("FAIL led_out: got %h want a5", leds);
        end
        drive(BASE + 32'h0D, 0, 1'b1, 1'b0);
        nChecks++;
        if (rdata !== 32'h000000A5) begin
            nFails++;
            $display("FAIL led_read: got %h want 000000a5", rdata);
        end
        tick();
        drive(32'h50000000, 0, 1'b1, 1'b0);
        nChecks++;
        if ({hit, rdata} !== {1'b0, 32'd0}) begin
            nFails++;
            $display("FAIL miss_read: got hit=%b rdata=%h want 0 00000000", hit, rdata);
        end
        tick();
    endtask

    task automatic test_timer();
        logic [31:0] seq [7];
        seq = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFFD,
                32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFC};
        drive(BASE + 32'h00, 32'hFFFFFFFC, 0, 1); tick();
        drive(BASE + 32'h04, 32'hFFFFFFFE, 0, 1); tick();
        drive(BASE + 32'h08, 32'd3, 0, 1);        tick();
        for (int i = 0; i < 7; i++) begin
            drive(BASE + 32'h04, 0, 1, 0);
            nChecks++;
            if ({rdata, irq} !== {seq[i], (i >= 2)}) begin
                nFails++;
                $display("FAIL timer_seq[%0d]: got tl=%h irq=%b want %h %b",
                         i, rdata, irq, seq[i], (i >= 2));
            end
            if (i < 6) tick();
        end
        drive(BASE + 32'h08, 32'd3, 0, 1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            if (j == 1) drive(0, 0, 0, 0);
            nChecks++;
            if (irq !== (j == 4)) begin
                nFails++;
                $display("FAIL timer_rearm[%0d]: got irq=%b want %b", j, irq, (j == 4));
            end
        end
    endtask

    task automatic test_collision();
        drive(BASE + 32'h08, 32'd0, 0, 1);        tick();
        drive(BASE + 32'h04, 32'hFFFFFFFF, 0, 1); tick();
        drive(BASE + 32'h08, 32'd1, 0, 1);        tick();
        drive(BASE + 32'h08, 32'd2, 0, 1);        tick();  // overflow cycle
        drive(BASE + 32'h08, 0, 1, 0);
        nChecks++;
        if ({rdata, irq} !== {32'd6, 1'b1}) begin
            nFails++;
            $display("FAIL collision_tcon: got tcon=%h irq=%b want 00000006 1", rdata, irq);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(BASE + 32'h04, 0, 1, 0);
            nChecks++;
            if (rdata !== 32'hFFFFFFFC) begin
                nFails++;
                $display("FAIL collision_tl_hold[%0d]: got %h want fffffffc", i, rdata);
            end
        end
        tick();
    endtask

    task automatic test_scan();
        logic [3:0] anTbl [4];
        logic [7:0] segTbl [4];
        int idx;
        anTbl  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        segTbl = '{8'h0E, 8'h00, 8'h03, 8'h30};
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(BASE + 32'h10, 32'h00013B8F, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            idx = int'((mCycles / SD) % 4);
            nChecks++;
            if ({an, bcd7} !== {anTbl[idx], segTbl[idx]}) begin
                nFails++;
                $display("FAIL scan[%0d]: got an=%b bcd7=%h want %b %h",
                         i, an, bcd7, anTbl[idx], segTbl[idx]);
            end
            tick();
        end
    endtask

    task automatic test_systick();
        logic [31:0] want;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
`ifdef MMIO_SYSTICK_EN
        want = 32'd10;
`else
        want = 32'd0;
`endif
        drive(BASE + 32'h14, 0, 1, 0);
        nChecks++;
        if (rdata !== want) begin
            nFails++;
            $display("FAIL systick_10: got %h want %h", rdata, want);
        end
        tick();
        drive(BASE + 32'h14, 32'h55, 0, 1);
        tick();
        drive(BASE + 32'h14, 0, 1, 0);
        nChecks++;
        if (rdata !== expRead(addr, rd_en)) begin
            nFails++;
            $display("FAIL systick_wr_ignored: got %h want %h", rdata, expRead(addr, rd_en));
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            a = ($urandom_range(0, 3) != 0) ? (BASE | ($urandom & 32'h1F)) : $urandom;
            d = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
            drive(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
            nChecks++;
            if ({hit, rdata} !== {(a[31:5] == BASE[31:5]), expRead(addr, rd_en)}) begin
                nFails++;
                $display("FAIL rand_read[%0d]: addr=%h got hit=%b rdata=%h want %b %h",
                         i, a, hit, rdata, (a[31:5] == BASE[31:5]), expRead(addr, rd_en));
            end
            tick();
            nChecks++;
            if ({leds, irq, an, bcd7} !== expOuts()) begin
                nFails++;
                $display("FAIL rand_outs[%0d]: got {leds,irq,an,bcd7}=%h want %h",
                         i, {leds, irq, an, bcd7}, expOuts());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_led();
        test_timer();
        test_collision();
        test_scan();
        test_systick();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mmio_peripherals.md
Name: mmio_peripherals

Overview:
- Memory-mapped peripheral block downstream of the pipeline's MEM stage.
- Consumes data-memory-stage loads/stores that fall in the peripheral window: a 32-bit timer with interrupt, an LED register, and a 4-digit seven-segment scan driver.
- Replaces direct LED/display driving inside data memory. Data memory muxes `rdata` in whenever `hit` is high.

Parameters:
- `BASE_ADDR`, `32'h40000000`: byte base of the 32-byte peripheral window.
- `SCAN_DIV`, `100000`: clock cycles per displayed digit; legal range 2 to 2^20.
- `SCAN_W`, `20`: width of the scan prescaler counter.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `addr` input 32: byte address from `ALUOut_MEM`.
- `wdata` input 32: store data.
- `rd_en` input 1: `MemRead` from the MEM stage.
- `wr_en` input 1: `MemWrite` from the MEM stage.
- `hit` output 1: `addr[31:5] == BASE_ADDR[31:5]`. Combinational, independent of `rd_en`/`wr_en`.
- `rdata` output 32: read data. Combinational.
- `irq` output 1: timer interrupt request.
- `leds` output 8: LED register.
- `bcd7` output 8: segment lines `{dp,g,f,e,d,c,b,a}`, active-low.
- `an` output 4: digit enables, active-low, one-hot.

Behaviour:
- Register map, offset is `addr[4:2]`; `addr[1:0]` ignored:
  - `0x00` `TH`: timer reload value, R/W.
  - `0x04` `TL`: timer count, R/W.
  - `0x08` `TCON[2:0]`: bit0 = enable, bit1 = irq enable, bit2 = status. R/W; bits [31:3] read 0.
  - `0x0C` `LED[7:0]`: R/W.
  - `0x10` `DIGITS[15:0]`: four hex nibbles; nibble k is shown on `an[k]`. Bit 16 gates all decimal points on; bits [31:17] read 0.
  - `0x14` `SYSTICK`: see Optional Feature.
  - `0x18`, `0x1C`: read 0; writes ignored.
- Writes:
  - Take effect at the `clk` edge when `wr_en && hit`.
  - Only the written register changes.
  - Byte stores are not supported: the full word is written.
- Reads:
  - `rdata` = selected register when `rd_en && hit`, else 0.
  - Zero-latency: reflects the current register value, not a value being written the same cycle.
- Timer, per cycle when `TCON[0]=1`:
  - If `TL == 32'hFFFFFFFF`: next `TL = TH`, and if `TCON[1]=1` set `TCON[2]`.
  - Otherwise `TL = TL + 1`.
  - When `TCON[0]=0`, `TL` holds its value.
- Simultaneous events:
  - A CPU write to `TL` overrides the increment/reload in that cycle.
  - A CPU write to `TCON` in an overflow cycle: `TCON[2]` becomes `wdata[2] | (wdata[1] & overflow)`, so an interrupt is never lost. Enable bits are taken from `wdata`. Overflow is evaluated using the old `TCON[0]`.
  - A CPU write to `TH` in an overflow cycle: the reload uses the old `TH`.
- Interrupt:
  - `irq` = `TCON[1] & TCON[2]`, registered-state derived.
  - Software clears it by writing `TCON[2]=0`.
- Scan driver:
  - Prescaler counts 0 to `SCAN_DIV-1` and wraps.
  - On wrap, the 2-bit digit index advances 0→1→2→3→0.
  - `an` = `~(4'b0001 << idx)`.
  - `bcd7[6:0]` = active-low hex decode of nibble `idx` (0-F; standard shapes, b and d lower-case).
  - `bcd7[7]` = `~DIGITS[16]`.
  - `an` and `bcd7` are registered: they update in the same edge as the index change.
- Reset:
  - `TH`, `TL`, `TCON`, `LED`, `DIGITS`, prescaler, index and `SYSTICK` all = 0.
  - Outputs after reset: `leds = 0`, `irq = 0`, `an = 4'b1110`, `bcd7 = 8'b11000000` (digit "0", dp off).
  - Reset asserted mid-count overrides all writes and counting in that cycle.

Optional Feature:
- Macro: `MMIO_SYSTICK_EN`.
- Defined:
  - `SYSTICK` is a free-running 32-bit cycle counter: +1 every cycle, wraps at `2^32` to 0, read-only (writes ignored).
  - Reset clears it to 0.
- Undefined:
  - No counter logic.
  - Offset `0x14` reads 0.

Test Plan:
- Reset, then idle 1 cycle → `leds=0`, `irq=0`, `an=1110`, `bcd7=0xC0`. Read `0x40000008` → `rdata=0`.
- Write `LED=0xA5`, then read `0x4000000C` → `leds=0xA5` from the next cycle; `rdata=0x000000A5`. Read `0x50000000` → `hit=0`, `rdata=0`.
- Timer reload and interrupt:
  - Setup: `TH=0xFFFFFFFC`, `TL=0xFFFFFFFE`, `TCON=3`.
  - Expected sequence: `TL` goes FFFFFFFF, then FFFFFFFC, FFFFFFFD, FFFFFFFE, FFFFFFFF, FFFFFFFC.
  - `irq` rises the cycle after the first reload.
  - Write `TCON=3` → `irq` drops; it rises again at the next overflow, 4 cycles later.
- Same-cycle collision: write `TCON=2` in the overflow cycle → `TCON` reads 6; `TL` holds thereafter.
- Display scan with `SCAN_DIV=4`:
  - Write `DIGITS=0x1_3B8F` → `an` steps 1110, 1101, 1011, 0111 every 4 cycles.
  - `bcd7` = 0x0E (F), 0x00 (8), 0x03 (b), 0x30 (3), dp on.
- `MMIO_SYSTICK_EN` defined: reset, then 10 cycles → `SYSTICK` reads 10. Write `0x55` to `0x14` → no effect. Macro undefined → reads 0.
